// File: rtl/alu_pkg.sv
// Shared constants for the ALU control stage: ALUOp classes, funct/opcode values,
// ALU operation codes and the multi-cycle FSM state type.
package alu_pkg;

    localparam logic [1:0] ALUOP_RTYPE  = 2'b00;
    localparam logic [1:0] ALUOP_MEM    = 2'b01;
    localparam logic [1:0] ALUOP_BRANCH = 2'b10;
    localparam logic [1:0] ALUOP_IMM    = 2'b11;

    localparam logic [5:0] FUNCT_SLL  = 6'd0;
    localparam logic [5:0] FUNCT_SRL  = 6'd2;
    localparam logic [5:0] FUNCT_JR   = 6'd8;
    localparam logic [5:0] FUNCT_MULT = 6'd24;
    localparam logic [5:0] FUNCT_DIV  = 6'd26;
    localparam logic [5:0] FUNCT_ADD  = 6'd32;
    localparam logic [5:0] FUNCT_SUB  = 6'd34;
    localparam logic [5:0] FUNCT_AND  = 6'd36;
    localparam logic [5:0] FUNCT_OR   = 6'd37;
    localparam logic [5:0] FUNCT_NOR  = 6'd39;
    localparam logic [5:0] FUNCT_SLT  = 6'd42;

    localparam logic [5:0] OP_ADDI = 6'd8;
    localparam logic [5:0] OP_SLTI = 6'd10;
    localparam logic [5:0] OP_ANDI = 6'd12;
    localparam logic [5:0] OP_ORI  = 6'd13;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_MULT = 4'b1010;
    localparam logic [3:0] ALU_DIV  = 4'b1011;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_NOP  = 4'b1111;

    typedef logic [1:0] muldiv_state_t;
    localparam muldiv_state_t ST_IDLE = 2'd0;
    localparam muldiv_state_t ST_BUSY = 2'd1;
    localparam muldiv_state_t ST_DONE = 2'd2;

endpackage

// File: rtl/alu_decode_comb.sv
// Pure combinational ALU control decode table.
// ALU_CONTROL_MULDIV_EN adds mult/div codes and the muldiv start flag.
import alu_pkg::*;

module alu_decode_comb #(
    parameter int ALUCTL_W = 4
) (
    input  logic [1:0]          alu_op,
    input  logic [5:0]          funct,
    input  logic [5:0]          opcode,
`ifdef ALU_CONTROL_MULDIV_EN
    output logic                muldiv,
`endif
    output logic [ALUCTL_W-1:0] code,
    output logic                jr
);

    logic [3:0] code4;
    logic       muldiv_int;

    always_comb begin
        code4      = ALU_NOP;
        jr         = 1'b0;
        muldiv_int = 1'b0;
        case (alu_op)
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: code4 = ALU_ADD;
                    FUNCT_SUB: code4 = ALU_SUB;
                    FUNCT_AND: code4 = ALU_AND;
                    FUNCT_OR:  code4 = ALU_OR;
                    FUNCT_NOR: code4 = ALU_NOR;
                    FUNCT_SLT: code4 = ALU_SLT;
                    FUNCT_SLL: code4 = ALU_SLL;
                    FUNCT_SRL: code4 = ALU_SRL;
                    FUNCT_JR: begin
                        code4 = ALU_ADD;
                        jr    = 1'b1;
                    end
`ifdef ALU_CONTROL_MULDIV_EN
                    FUNCT_MULT: begin
                        code4      = ALU_MULT;
                        muldiv_int = 1'b1;
                    end
                    FUNCT_DIV: begin
                        code4      = ALU_DIV;
                        muldiv_int = 1'b1;
                    end
`endif
                    default: code4 = ALU_NOP;
                endcase
            end
            ALUOP_MEM:    code4 = ALU_ADD;
            ALUOP_BRANCH: code4 = ALU_SUB;
            ALUOP_IMM: begin
                case (opcode)
                    OP_ADDI: code4 = ALU_ADD;
                    OP_ANDI: code4 = ALU_AND;
                    OP_ORI:  code4 = ALU_OR;
                    OP_SLTI: code4 = ALU_SLT;
                    default: code4 = ALU_NOP;
                endcase
            end
            default: code4 = ALU_NOP;
        endcase
    end

    // Codes are zero-extended when ALUCTL_W is wider than the 4-bit table.
    assign code = ALUCTL_W'(code4);

`ifdef ALU_CONTROL_MULDIV_EN
    assign muldiv = muldiv_int;
`else
    logic unused_muldiv;
    assign unused_muldiv = muldiv_int;
`endif

endmodule

// File: rtl/alu_control_stage.sv
// Registered ALU control decode with optional multi-cycle mult/div sequencer.
// ALU_CONTROL_MULDIV_EN compiles in the IDLE/BUSY/DONE FSM and its counter.
import alu_pkg::*;

module alu_control_stage #(
    parameter int ALUCTL_W      = 4,
    parameter int MULDIV_CYCLES = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [1:0]          ALUOp,
    input  logic [5:0]          Function,
    input  logic [5:0]          Opcode,
    input  logic                flush,
    output logic [ALUCTL_W-1:0] ALUControl,
    output logic                JRControl,
    output logic                out_valid,
    output logic                stall,
    output logic                muldiv_done
);

    logic [ALUCTL_W-1:0] dec_code;
    logic                dec_jr;

`ifdef ALU_CONTROL_MULDIV_EN
    logic dec_muldiv;

    alu_decode_comb #(.ALUCTL_W(ALUCTL_W)) u_decode (
        .alu_op (ALUOp),
        .funct  (Function),
        .opcode (Opcode),
        .muldiv (dec_muldiv),
        .code   (dec_code),
        .jr     (dec_jr)
    );
`else
    alu_decode_comb #(.ALUCTL_W(ALUCTL_W)) u_decode (
        .alu_op (ALUOp),
        .funct  (Function),
        .opcode (Opcode),
        .code   (dec_code),
        .jr     (dec_jr)
    );
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            ALUControl <= ALUCTL_W'(ALU_NOP);
            JRControl  <= 1'b0;
            out_valid  <= 1'b0;
        end else if (flush) begin
            JRControl <= 1'b0;
            out_valid <= 1'b0;
        end else if (stall) begin
            out_valid <= 1'b0;
        end else if (in_valid) begin
            ALUControl <= dec_code;
            JRControl  <= dec_jr;
            out_valid  <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end

`ifdef ALU_CONTROL_MULDIV_EN
    localparam int CNT_W = $clog2(MULDIV_CYCLES);
    // Loaded with cycles-2 and checked for zero before decrementing, so BUSY lasts cycles-1.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 2);

    muldiv_state_t    state;
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            count <= '0;
        end else if (flush) begin
            state <= ST_IDLE;
            count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && dec_muldiv) begin
                        state <= ST_BUSY;
                        count <= CNT_LOAD;
                    end
                end
                ST_BUSY: begin
                    if (count == '0) begin
                        state <= ST_DONE;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign stall       = (state == ST_BUSY);
    assign muldiv_done = (state == ST_DONE);
`else
    assign stall       = 1'b0;
    assign muldiv_done = 1'b0;
`endif

endmodule
